// File: rtl/map_frame_build_pkg.sv
// Shared definitions for the key-frame builder: FSM encoding, frame byte offsets
// (common with the key extractor) and fixed IPv4/L4 header constants.
package map_frame_build_pkg;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        CALC_S     = 2'd1,
        TRANSMIT_S = 2'd2,
        GAP_S      = 2'd3
    } state_e;

    // Byte offsets must stay in step with the extractor.
    localparam int unsigned OFS_ETYPE   = 12;
    localparam int unsigned OFS_IPHDR   = 14;
    localparam int unsigned OFS_TOTLEN  = 16;
    localparam int unsigned OFS_ID      = 18;
    localparam int unsigned OFS_FLAGS   = 20;
    localparam int unsigned OFS_TTL     = 22;
    localparam int unsigned OFS_PROTO   = 23;
    localparam int unsigned OFS_CSUM    = 24;
    localparam int unsigned OFS_SIP     = 26;
    localparam int unsigned OFS_DIP     = 30;
    localparam int unsigned OFS_SPORT   = 34;
    localparam int unsigned OFS_DPORT   = 36;
    localparam int unsigned OFS_L4LEN   = 38;
    localparam int unsigned OFS_TCP_OFF = 46;
    localparam int unsigned FRAME_LEN   = 60;

    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [15:0] IPV4_VER_TOS    = 16'h4500;
    localparam logic [15:0] IPV4_TOT_LEN    = 16'h002E;
    localparam logic [15:0] IPV4_FLAGS_FRAG = 16'h4000;
    localparam logic [15:0] UDP_LEN         = 16'h001A;
    localparam logic [7:0]  PROTO_TCP       = 8'h06;
    localparam logic [7:0]  PROTO_UDP       = 8'h11;
    localparam logic [7:0]  TCP_DATA_OFS    = 8'h50;

    typedef struct packed {
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sport;
        logic [15:0] dport;
    } tuple_t;

endpackage

// File: rtl/map_frame_build_if.sv
// Descriptor-in / byte-stream-out bundle of the key-frame builder.
interface map_frame_build_if;

    logic [103:0] iv_5tuple_data;
    logic         i_5tuple_data_wr;
    logic [47:0]  iv_dmac;
    logic [8:0]   iv_bufid;
    logic         i_tcp_or_udp_flag;
    logic [8:0]   ov_data;
    logic         o_data_wr;
    logic [8:0]   ov_bufid;
    logic         o_busy;

    modport master (
        output iv_5tuple_data,
        output i_5tuple_data_wr,
        output iv_dmac,
        output iv_bufid,
        output i_tcp_or_udp_flag,
        input  ov_data,
        input  o_data_wr,
        input  ov_bufid,
        input  o_busy
    );

    modport slave (
        input  iv_5tuple_data,
        input  i_5tuple_data_wr,
        input  iv_dmac,
        input  iv_bufid,
        input  i_tcp_or_udp_flag,
        output ov_data,
        output o_data_wr,
        output ov_bufid,
        output o_busy
    );

endinterface

// File: rtl/ipv4_csum_calc.sv
// Combinational IPv4 header checksum over ten 16-bit words (checksum field zero).
module ipv4_csum_calc (
    input  logic [159:0] hdr_i,
    output logic [15:0]  csum_o
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // The second fold can carry at most one, so 16 bits hold its result.
    always_comb begin
        sum = 20'h0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'h0, hdr_i[16*i +: 16]};
        end
        fold1  = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
        fold2  = fold1[15:0] + {15'h0, fold1[16]};
        csum_o = ~fold2;
    end

endmodule

// File: rtl/map_frame_build.sv
// Builds a 60-byte Ethernet/IPv4 (or non-IP) key frame from a 5-tuple + DMAC and streams it
// out one byte per cycle. Define IPV4_CSUM_EN to fill in the IPv4 header checksum.
module map_frame_build
    import map_frame_build_pkg::*;
#(
    parameter logic [47:0] LOCAL_SMAC      = 48'h0,
    parameter logic [15:0] NON_IP_ETH_TYPE = 16'h88B5,
    parameter logic [7:0]  IP_TTL          = 8'd64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    map_frame_build_if.slave bus
);

    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    state_e      state_q;
    tuple_t      tuple_q;
    logic [47:0] dmac_q;
    logic        ip_q;
    logic [15:0] id_q;
    logic [15:0] csum_q;
    logic [5:0]  cnt_q;
    logic [8:0]  data_q;
    logic        wr_q;
    logic [8:0]  bufid_q;
    logic        busy_q;

    logic [15:0] csum_w;
    logic [5:0]  nxt_idx;
    logic [7:0]  frame_w [FRAME_LEN];

`ifdef IPV4_CSUM_EN
    logic [159:0] hdr_w;

    assign hdr_w = {IPV4_VER_TOS, IPV4_TOT_LEN, id_q, IPV4_FLAGS_FRAG, IP_TTL, tuple_q.proto,
                    16'h0000, tuple_q.sip, tuple_q.dip};

    ipv4_csum_calc u_csum (
        .hdr_i  (hdr_w),
        .csum_o (csum_w)
    );
`else
    assign csum_w = 16'h0000;
`endif

    // Byte index to be presented after the next edge; CALC_S preloads byte 0.
    assign nxt_idx = (state_q == TRANSMIT_S && cnt_q != LAST_IDX) ? cnt_q + 6'd1 : 6'd0;

    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            frame_w[i] = 8'h00;
        end
        for (int i = 0; i < 6; i++) begin
            frame_w[i]     = dmac_q[8*(5-i) +: 8];
            frame_w[6 + i] = LOCAL_SMAC[8*(5-i) +: 8];
        end
        if (ip_q) begin
            frame_w[OFS_ETYPE]      = ETH_TYPE_IPV4[15:8];
            frame_w[OFS_ETYPE + 1]  = ETH_TYPE_IPV4[7:0];
            frame_w[OFS_IPHDR]      = IPV4_VER_TOS[15:8];
            frame_w[OFS_IPHDR + 1]  = IPV4_VER_TOS[7:0];
            frame_w[OFS_TOTLEN]     = IPV4_TOT_LEN[15:8];
            frame_w[OFS_TOTLEN + 1] = IPV4_TOT_LEN[7:0];
            frame_w[OFS_ID]         = id_q[15:8];
            frame_w[OFS_ID + 1]     = id_q[7:0];
            frame_w[OFS_FLAGS]      = IPV4_FLAGS_FRAG[15:8];
            frame_w[OFS_FLAGS + 1]  = IPV4_FLAGS_FRAG[7:0];
            frame_w[OFS_TTL]        = IP_TTL;
            frame_w[OFS_PROTO]      = tuple_q.proto;
            frame_w[OFS_CSUM]       = csum_q[15:8];
            frame_w[OFS_CSUM + 1]   = csum_q[7:0];
            for (int i = 0; i < 4; i++) begin
                frame_w[OFS_SIP + i] = tuple_q.sip[8*(3-i) +: 8];
                frame_w[OFS_DIP + i] = tuple_q.dip[8*(3-i) +: 8];
            end
            for (int i = 0; i < 2; i++) begin
                frame_w[OFS_SPORT + i] = tuple_q.sport[8*(1-i) +: 8];
                frame_w[OFS_DPORT + i] = tuple_q.dport[8*(1-i) +: 8];
            end
            if (tuple_q.proto == PROTO_UDP) begin
                frame_w[OFS_L4LEN]     = UDP_LEN[15:8];
                frame_w[OFS_L4LEN + 1] = UDP_LEN[7:0];
            end
            if (tuple_q.proto == PROTO_TCP) begin
                frame_w[OFS_TCP_OFF] = TCP_DATA_OFS;
            end
        end else begin
            frame_w[OFS_ETYPE]     = NON_IP_ETH_TYPE[15:8];
            frame_w[OFS_ETYPE + 1] = NON_IP_ETH_TYPE[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE_S;
            tuple_q <= '0;
            dmac_q  <= '0;
            ip_q    <= 1'b0;
            id_q    <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            bufid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE_S: begin
                    if (bus.i_5tuple_data_wr) begin
                        tuple_q <= bus.iv_5tuple_data;
                        dmac_q  <= bus.iv_dmac;
                        bufid_q <= bus.iv_bufid;
                        ip_q    <= bus.i_tcp_or_udp_flag;
                        busy_q  <= 1'b1;
                        state_q <= CALC_S;
                    end
                end
                CALC_S: begin
                    csum_q  <= csum_w;
                    cnt_q   <= '0;
                    data_q  <= {1'b1, frame_w[nxt_idx]};
                    wr_q    <= 1'b1;
                    state_q <= TRANSMIT_S;
                end
                TRANSMIT_S: begin
                    if (cnt_q == LAST_IDX) begin
                        data_q  <= '0;
                        wr_q    <= 1'b0;
                        bufid_q <= '0;
                        if (ip_q) begin
                            id_q <= id_q + 16'd1;
                        end
                        state_q <= GAP_S;
                    end else begin
                        cnt_q  <= nxt_idx;
                        data_q <= {nxt_idx == LAST_IDX, frame_w[nxt_idx]};
                    end
                end
                GAP_S: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE_S;
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end

    assign bus.ov_data   = data_q;
    assign bus.o_data_wr = wr_q;
    assign bus.ov_bufid  = bufid_q;
    assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_map_frame_build.sv
// Bench for map_frame_build: table of descriptors, a byte scoreboard fed at strobe time,
// and hand sequences for latency, busy drop, ID wrap and mid-frame reset.
module tb_map_frame_build;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    map_frame_build_if bus ();

    map_frame_build dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [103:0] tuple;
        logic [47:0]  dmac;
        logic [8:0]   bufid;
        logic         flag;
        logic [15:0]  exp_etype;
        logic [15:0]  exp_l4len;
        logic [7:0]   exp_b46;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic [8:0] bufid;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          have_acc = 1'b0;
    logic [15:0] m_id = 16'h0;
    logic [7:0]  rx_buf[64];
    logic [7:0]  last_frame[64];
    int          rx_cnt = 0;
    int          last_len = 0;
    int          frames_rx = 0;
    int          target = 0;
    vec_t        vecs[5];
    vec_t        udp;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_csum(input logic [103:0] t, input logic [15:0] id);
`ifdef IPV4_CSUM_EN
        logic [31:0] s;
        s = 32'h4500 + 32'h002E + {16'h0, id} + 32'h4000 + {16'h0, 8'd64, t[103:96]}
            + {16'h0, t[95:80]} + {16'h0, t[79:64]} + {16'h0, t[63:48]} + {16'h0, t[47:32]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic push_frame(input vec_t v, input logic [15:0] id);
        logic [7:0]  f[60];
        logic [15:0] cs;
        for (int i = 0; i < 60; i++) f[i] = 8'h00;
        for (int i = 0; i < 6; i++) f[i] = v.dmac[8*(5-i) +: 8];
        if (v.flag) begin
            cs = model_csum(v.tuple, id);
            f[12] = 8'h08; f[14] = 8'h45; f[17] = 8'h2E;
            f[18] = id[15:8]; f[19] = id[7:0];
            f[20] = 8'h40; f[22] = 8'd64; f[23] = v.tuple[103:96];
            f[24] = cs[15:8]; f[25] = cs[7:0];
            for (int i = 0; i < 12; i++) f[26 + i] = v.tuple[95 - 8*i -: 8];
            if (v.tuple[103:96] == 8'h11) f[39] = 8'h1A;
            if (v.tuple[103:96] == 8'h06) f[46] = 8'h50;
        end else begin
            f[12] = 8'h88; f[13] = 8'hB5;
        end
        for (int i = 0; i < 60; i++) begin
            exp_q.push_back('{data: {(i == 0 || i == 59), f[i]}, bufid: v.bufid});
        end
    endtask

    // Drive a one-cycle strobe; the model decides whether the DUT should accept it.
    task automatic send(input vec_t v);
        int sc;
        @(posedge clk);
        #1;
        bus.iv_5tuple_data    = v.tuple;
        bus.iv_dmac           = v.dmac;
        bus.iv_bufid          = v.bufid;
        bus.i_tcp_or_udp_flag = v.flag;
        bus.i_5tuple_data_wr  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_5tuple_data_wr = 1'b0;
        sc = cyc;
        if (!have_acc || (sc - last_acc >= 63)) begin
            have_acc = 1'b1;
            last_acc = sc;
            push_frame(v, m_id);
            if (v.flag) m_id = m_id + 16'd1;
        end
    endtask

    task automatic wait_frames(input int tgt);
        for (int i = 0; i < 300 && frames_rx < tgt; i++) @(negedge clk);
        chk("frame_done", 128'(frames_rx), 128'(tgt));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && bus.o_busy; i++) @(negedge clk);
    endtask

    task automatic chk16(input string name, input int ofs, input logic [15:0] exp);
        chk(name, {112'h0, last_frame[ofs], last_frame[ofs + 1]}, {112'h0, exp});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard consumer and frame reassembler.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && bus.o_data_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {119'h0, bus.ov_data}, 128'h0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("byte%0d", rx_cnt), {119'h0, bus.ov_data}, {119'h0, e.data});
                chk("bufid", {119'h0, bus.ov_bufid}, {119'h0, e.bufid});
            end
            if (rx_cnt < 64) rx_buf[rx_cnt] = bus.ov_data[7:0];
            if (bus.ov_data[8] && rx_cnt != 0) begin
                last_frame = rx_buf;
                last_len   = rx_cnt + 1;
                frames_rx++;
                rx_cnt = 0;
            end else if (rx_cnt < 63) begin
                rx_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] rtuple;
        logic [47:0]  rdmac;
        logic [7:0]   zor;

        udp = '{tuple: {8'h11, 32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h5678},
                dmac: 48'h010203040506, bufid: 9'h05A, flag: 1'b1,
                exp_etype: 16'h0800, exp_l4len: 16'h001A, exp_b46: 8'h00};
        vecs[0] = udp;
        vecs[0].bufid = 9'h1FF;
        vecs[1] = '{tuple: {8'h11, 32'h01020304, 32'h05060708, 16'h0001, 16'h0002},
                    dmac: 48'hFFFFFFFFFFFF, bufid: 9'h100, flag: 1'b0,
                    exp_etype: 16'h88B5, exp_l4len: 16'h0000, exp_b46: 8'h00};
        vecs[2] = '{tuple: {8'h06, 32'h0A000001, 32'h0A000002, 16'h0050, 16'hC350},
                    dmac: 48'hAABBCCDDEEFF, bufid: 9'h033, flag: 1'b1,
                    exp_etype: 16'h0800, exp_l4len: 16'h0000, exp_b46: 8'h50};
        vecs[3] = '{tuple: {8'h01, 32'hFFFFFFFF, 32'h00000000, 16'hFFFF, 16'h0000},
                    dmac: 48'h000000000001, bufid: 9'h001, flag: 1'b1,
                    exp_etype: 16'h0800, exp_l4len: 16'h0000, exp_b46: 8'h00};
        vecs[4] = '{tuple: {8'h06, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1111, 16'h2222},
                    dmac: 48'h123456789ABC, bufid: 9'h0AA, flag: 1'b0,
                    exp_etype: 16'h88B5, exp_l4len: 16'h0000, exp_b46: 8'h00};

        bus.iv_5tuple_data    = '0;
        bus.i_5tuple_data_wr  = 1'b0;
        bus.iv_dmac           = '0;
        bus.iv_bufid          = '0;
        bus.i_tcp_or_udp_flag = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_data", {119'h0, bus.ov_data}, 128'h0);
        chk("reset_wr", {127'h0, bus.o_data_wr}, 128'h0);
        chk("reset_bufid", {119'h0, bus.ov_bufid}, 128'h0);
        chk("reset_busy", {127'h0, bus.o_busy}, 128'h0);
        rst_n = 1'b1;

        // Latency, busy drop and ID increment.
        send(udp);
        chk("lat_wr_cycle1", {127'h0, bus.o_data_wr}, 128'h0);
        chk("busy_after_strobe", {127'h0, bus.o_busy}, 128'h1);
        @(posedge clk);
        #1;
        chk("lat_wr_cycle2", {127'h0, bus.o_data_wr}, 128'h1);
        chk("lat_byte0", {119'h0, bus.ov_data}, 128'h101);
        repeat (7) @(posedge clk);
        send(udp);
        chk("busy_at_drop", {127'h0, bus.o_busy}, 128'h1);
        repeat (51) @(posedge clk);
        target = 1;
        wait_frames(target);
        chk("udp_len", 128'(last_len), 128'd60);
`ifdef IPV4_CSUM_EN
        chk16("udp_csum", 24, 16'hB76B);
`else
        chk16("udp_csum", 24, 16'h0000);
`endif
        chk16("udp_l4len", 38, 16'h001A);
        chk16("udp_id0", 18, 16'h0000);
        send(udp);
        target = 2;
        wait_frames(target);
        chk16("third_id1", 18, 16'h0001);
        wait_idle();
        chk("drop_no_extra", 128'(frames_rx), 128'd2);

        // Table of descriptors.
        for (int k = 0; k < 5; k++) begin
            logic [15:0] id_before;
            id_before = m_id;
            send(vecs[k]);
            target++;
            wait_frames(target);
            chk($sformatf("v%0d_len", k), 128'(last_len), 128'd60);
            chk16($sformatf("v%0d_etype", k), 12, vecs[k].exp_etype);
            chk16($sformatf("v%0d_l4len", k), 38, vecs[k].exp_l4len);
            chk($sformatf("v%0d_b46", k), {120'h0, last_frame[46]}, {120'h0, vecs[k].exp_b46});
            for (int i = 0; i < 6; i++) rdmac[8*(5-i) +: 8] = last_frame[i];
            chk($sformatf("v%0d_dmac", k), {80'h0, rdmac}, {80'h0, vecs[k].dmac});
            if (vecs[k].flag) begin
                rtuple[103:96] = last_frame[23];
                for (int i = 0; i < 12; i++) rtuple[95 - 8*i -: 8] = last_frame[26 + i];
                chk($sformatf("v%0d_loopback", k), {24'h0, rtuple}, {24'h0, vecs[k].tuple});
                chk16($sformatf("v%0d_id", k), 18, id_before);
            end else begin
                zor = 8'h00;
                for (int i = 14; i < 60; i++) zor = zor | last_frame[i];
                chk($sformatf("v%0d_nonip_zero", k), {120'h0, zor}, 128'h0);
            end
            wait_idle();
        end

        // ID wrap.
        force dut.id_q = 16'hFFFF;
        @(negedge clk);
        release dut.id_q;
        m_id = 16'hFFFF;
        send(udp);
        target++;
        wait_frames(target);
        chk16("wrap_idffff", 18, 16'hFFFF);
        wait_idle();
        send(udp);
        target++;
        wait_frames(target);
        chk16("wrap_id0000", 18, 16'h0000);
        wait_idle();

        // Asynchronous reset in the middle of a frame.
        send(udp);
        for (int i = 0; i < 100 && rx_cnt < 31; i++) @(negedge clk);
        chk("reset_reach_byte30", 128'(rx_cnt), 128'd31);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", {119'h0, bus.ov_data}, 128'h0);
        chk("midrst_wr", {127'h0, bus.o_data_wr}, 128'h0);
        chk("midrst_bufid", {119'h0, bus.ov_bufid}, 128'h0);
        chk("midrst_busy", {127'h0, bus.o_busy}, 128'h0);
        exp_q.delete();
        rx_cnt   = 0;
        have_acc = 1'b0;
        m_id     = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        send(udp);
        target++;
        wait_frames(target);
        chk("postrst_len", 128'(last_len), 128'd60);
        chk16("postrst_id", 18, 16'h0000);
        wait_idle();
        chk("sb_drained", 128'(exp_q.size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
